// File: rtl/bip_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bip_ctrl_pkg;

   // Opcode map (instruction MSBs)
   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;
   localparam logic [4:0] OP_JMP  = 5'b01000;
   localparam logic [4:0] OP_BEQ  = 5'b01001;
   localparam logic [4:0] OP_BNE  = 5'b01010;

   // Accumulator source select
   localparam logic [1:0] SEL_RAM = 2'b00;
   localparam logic [1:0] SEL_IMM = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   // Run/halt FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

endpackage

// File: rtl/bip_opcode_decoder.sv
// Maps an opcode to raw (ungated) datapath strobes and branch/halt/illegal flags.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the parent gates everything with its retire condition.
module bip_opcode_decoder
   import bip_ctrl_pkg::*;
#(
   parameter int NB_OPCODE = 5
) (
   input  logic [NB_OPCODE-1:0] i_opcode,
   output logic [1:0]           o_selA,
   output logic                 o_selB,
   output logic                 o_op,
   output logic                 o_wr_acc,
   output logic                 o_wr_ram,
   output logic                 o_rd_ram,
   output logic                 o_is_jmp,
   output logic                 o_is_beq,
   output logic                 o_is_bne,
   output logic                 o_is_hlt,
   output logic                 o_is_illegal
);

   // Opcode table; anything not listed decodes as an illegal NOP.
   always_comb begin
      o_selA       = SEL_RAM;
      o_selB       = 1'b0;
      o_op         = 1'b0;
      o_wr_acc     = 1'b0;
      o_wr_ram     = 1'b0;
      o_rd_ram     = 1'b0;
      o_is_jmp     = 1'b0;
      o_is_beq     = 1'b0;
      o_is_bne     = 1'b0;
      o_is_hlt     = 1'b0;
      o_is_illegal = 1'b0;
      case (i_opcode)
         NB_OPCODE'(OP_HLT):  o_is_hlt = 1'b1;
         NB_OPCODE'(OP_STO):  o_wr_ram = 1'b1;
         NB_OPCODE'(OP_LD): begin
            o_rd_ram = 1'b1;
            o_selA   = SEL_RAM;
            o_wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_LDI): begin
            o_selA   = SEL_IMM;
            o_wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
            o_rd_ram = 1'b1;
            o_selB   = 1'b0;
            o_op     = (i_opcode == NB_OPCODE'(OP_SUB));
            o_selA   = SEL_ALU;
            o_wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
            o_selB   = 1'b1;
            o_op     = (i_opcode == NB_OPCODE'(OP_SUBI));
            o_selA   = SEL_ALU;
            o_wr_acc = 1'b1;
         end
         NB_OPCODE'(OP_JMP):  o_is_jmp = 1'b1;
         NB_OPCODE'(OP_BEQ):  o_is_beq = 1'b1;
         NB_OPCODE'(OP_BNE):  o_is_bne = 1'b1;
         default:             o_is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/bip_branch_control.sv
// Control unit for the accumulator CPU: run/halt FSM, PC with branches, retire counter.
// Latency: strobes are combinational (0 cycles); PC/state/counter update on the next edge.
// Backpressure: i_stall freezes the current instruction; nothing retires while it is high.
module bip_branch_control
   import bip_ctrl_pkg::*;
#(
   parameter int NB_OPCODE      = 5,
   parameter int NB_INSTRUCTION = 16,
   parameter int NB_ADDRESS     = 11,
   parameter int NB_OPERAND     = 11,
   parameter int NB_COUNT       = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic                      i_stall,
   input  logic                      i_zero,
   input  logic [NB_INSTRUCTION-1:0] i_pm_instruction,
   output logic [NB_ADDRESS-1:0]     o_pm_address,
   output logic [NB_OPERAND-1:0]     o_operand,
   output logic [1:0]                o_selA,
   output logic                      o_selB,
   output logic                      o_wr_Acc,
   output logic                      o_op,
   output logic                      o_wr_Ram,
   output logic                      o_rd_Ram,
   output logic                      o_wr_PC,
   output logic                      o_busy,
   output logic                      o_halted,
   output logic                      o_illegal,
   output logic [NB_COUNT-1:0]       o_instr_count
);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [NB_ADDRESS-1:0]   r_pc;
   logic [NB_ADDRESS-1:0]   w_pc_next;
   logic [NB_COUNT-1:0]     r_count;
   logic [NB_OPCODE-1:0]    w_opcode;
   logic [NB_ADDRESS-1:0]   w_target;
   logic                    w_retire;
   logic                    w_taken;
   logic                    w_restart;

   logic [1:0] w_dec_selA;
   logic       w_dec_selB, w_dec_op, w_dec_wr_acc, w_dec_wr_ram, w_dec_rd_ram;
   logic       w_is_jmp, w_is_beq, w_is_bne, w_is_hlt, w_is_illegal;

   assign w_opcode  = i_pm_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];
   assign o_operand = i_pm_instruction[NB_OPERAND-1:0];
   assign w_target  = NB_ADDRESS'(o_operand);

   bip_opcode_decoder #(
      .NB_OPCODE    (NB_OPCODE)
   ) u_decoder (
      .i_opcode     (w_opcode),
      .o_selA       (w_dec_selA),
      .o_selB       (w_dec_selB),
      .o_op         (w_dec_op),
      .o_wr_acc     (w_dec_wr_acc),
      .o_wr_ram     (w_dec_wr_ram),
      .o_rd_ram     (w_dec_rd_ram),
      .o_is_jmp     (w_is_jmp),
      .o_is_beq     (w_is_beq),
      .o_is_bne     (w_is_bne),
      .o_is_hlt     (w_is_hlt),
      .o_is_illegal (w_is_illegal)
   );

   // An instruction completes only in RUN with the datapath ready.
   assign w_retire  = (r_state == ST_RUN) && !i_stall;
   assign w_restart = (r_state != ST_RUN) && i_start;
   assign w_taken   = w_is_jmp || (w_is_beq && i_zero) || (w_is_bne && !i_zero);
   assign w_pc_next = w_taken ? w_target : r_pc + NB_ADDRESS'(1);

   // Retire-gated strobes; selects are forced to 0 when nothing consumes them.
   assign o_selA    = w_retire ? w_dec_selA : SEL_RAM;
   assign o_selB    = w_retire & w_dec_selB;
   assign o_op      = w_retire & w_dec_op;
   assign o_wr_Acc  = w_retire & w_dec_wr_acc;
   assign o_wr_Ram  = w_retire & w_dec_wr_ram;
   assign o_rd_Ram  = w_retire & w_dec_rd_ram;
   assign o_wr_PC   = w_retire & ~w_is_hlt;
   assign o_illegal = w_retire & w_is_illegal;

   assign o_pm_address  = r_pc;
   assign o_instr_count = r_count;
   assign o_busy        = (r_state == ST_RUN);
   assign o_halted      = (r_state == ST_HALT);

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // FSM next state: start leaves IDLE/HALT, a retiring HLT leaves RUN.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (i_start)              w_state_next = ST_RUN;
         ST_RUN:  if (w_retire && w_is_hlt) w_state_next = ST_HALT;
         ST_HALT: if (i_start)              w_state_next = ST_RUN;
         default:                           w_state_next = ST_IDLE;
      endcase
   end

   // PC: reload to 0 on (re)start, otherwise follow every retiring non-HLT instruction.
   always_ff @(posedge i_clk) begin
      if (i_reset)                   r_pc <= '0;
      else if (w_restart)            r_pc <= '0;
      else if (w_retire && !w_is_hlt) r_pc <= w_pc_next;
   end

   // Retired-instruction counter, saturating at all-ones; survives HALT->RUN.
   always_ff @(posedge i_clk) begin
      if (i_reset)                       r_count <= '0;
      else if (w_retire && r_count != '1) r_count <= r_count + NB_COUNT'(1);
   end

endmodule

// File: doc/bip_branch_control.md
Name: bip_branch_control

Overview:
- Next-generation control unit for the accumulator CPU; sits between program memory and the datapath (accumulator/ALU/data RAM).
- Adds a run/halt FSM, conditional and unconditional branches, a datapath stall input, illegal-opcode detection and a retired-instruction counter.
- All widths are parametrised.

Parameters:
- NB_OPCODE, 5, opcode field width (instruction MSBs).
- NB_INSTRUCTION, 16, instruction width.
- NB_ADDRESS, 11, program-memory address / PC width.
- NB_OPERAND, 11, operand field width (instruction LSBs).
- NB_COUNT, 16, retired-instruction counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  level; starts execution from IDLE or HALT.
- i_stall  in  1  datapath not ready; freezes the current instruction.
- i_zero  in  1  accumulator==0 flag from the datapath.
- i_pm_instruction  in  NB_INSTRUCTION  instruction read combinationally at o_pm_address.
- o_pm_address  out  NB_ADDRESS  registered PC.
- o_operand  out  NB_OPERAND  i_pm_instruction[NB_OPERAND-1:0], passed through ungated.
- o_selA  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU.
- o_selB  out  1  ALU B source: 0 RAM, 1 immediate.
- o_wr_Acc  out  1  accumulator write strobe.
- o_op  out  1  ALU operation: 0 add, 1 sub.
- o_wr_Ram  out  1  data-RAM write strobe.
- o_rd_Ram  out  1  data-RAM read strobe.
- o_wr_PC  out  1  PC advances or branches this cycle.
- o_busy  out  1  FSM is in RUN.
- o_halted  out  1  FSM is in HALT.
- o_illegal  out  1  one-cycle pulse when an undefined opcode retires.
- o_instr_count  out  NB_COUNT  retired-instruction count; saturates at all-ones.

Behaviour:
- Reset:
  - State IDLE, PC=0, o_instr_count=0.
  - All strobes, o_illegal, o_busy and o_halted are 0.
  - Reset has priority over every other input, including mid-RUN.
- FSM:
  - IDLE -> RUN on i_start=1.
  - RUN -> HALT when HLT retires.
  - HALT -> RUN on i_start=1, with PC reloaded to 0 and the counter preserved.
  - i_start is ignored while in RUN.
- Retire condition: state==RUN && !i_stall. Only a retiring instruction may assert o_wr_Acc, o_wr_Ram, o_rd_Ram, o_wr_PC or o_illegal, or change the counter.
- Strobes are combinational from the opcode, gated by the retire condition. Latency is 0 cycles from instruction to strobes; the PC update is visible on the next cycle.
- Opcodes:
  - HLT 00000: no strobes; PC holds.
  - STO 00001: wr_Ram.
  - LD 00010: rd_Ram, selA=00, wr_Acc.
  - LDI 00011: selA=01, wr_Acc.
  - ADD 00100: rd_Ram, selB=0, op=0, selA=10, wr_Acc.
  - ADDI 00101: selB=1, op=0, selA=10, wr_Acc.
  - SUB 00110: as ADD with op=1.
  - SUBI 00111: as ADDI with op=1.
  - JMP 01000: PC=target.
  - BEQ 01001: PC=target if i_zero, else PC+1.
  - BNE 01010: PC=target if !i_zero, else PC+1.
  - All others: NOP with o_illegal=1 and PC+1.
- PC update rules:
  - Every retiring instruction except HLT sets o_wr_PC=1.
  - Sequential increment wraps from 2^NB_ADDRESS-1 to 0.
  - target = operand zero-extended or truncated to NB_ADDRESS bits.
- Counter: increments on every retiring instruction, HLT included. It holds at all-ones once saturated.
- Stall: PC, state and counter hold. HLT under stall does not halt until i_stall drops.
- Don't-care outputs: o_selA, o_selB and o_op are 0 whenever no strobe uses them.

Decomposition:
- Package bip_ctrl_pkg contains:
  - opcode localparams (HLT..BNE);
  - selA encodings SEL_RAM, SEL_IMM, SEL_ALU;
  - FSM state encodings ST_IDLE, ST_RUN, ST_HALT.
- Sub-module bip_opcode_decoder is purely combinational. It maps opcode to raw strobes plus is_jmp, is_beq, is_bne, is_hlt and is_illegal. The parent applies retire gating and owns the PC, FSM and counter.

Test Plan:
- Reset-start check:
  - Stimulus: assert reset; raise i_start for 1 cycle; program LDI 5 / ADDI 3 / HLT.
  - Required response: after reset all strobes are 0 and PC=0; wr_Acc is seen at PC=0 and PC=1; o_halted=1 with PC=2; o_instr_count=3.
- Branch check:
  - Stimulus: BEQ 0x10 with i_zero=1, then BNE 0x20 at address 0x10 with i_zero=1.
  - Required response: PC goes 0 -> 0x10 -> 0x11; o_wr_PC=1 on both instructions.
- Stall check:
  - Stimulus: hold i_stall=1 for 3 cycles on STO.
  - Required response: o_wr_Ram=0 and PC is frozen during the stall; o_wr_Ram=1 for exactly 1 cycle after release.
- Wrap and illegal-opcode check:
  - Stimulus: opcode 11111 at PC=0x7FF.
  - Required response: o_illegal pulses once; PC wraps to 0x000; no writes occur.
- Mid-run reset and restart check:
  - Stimulus: reset at PC=0x005 during RUN; separately, issue i_start while in HALT.
  - Required response: the reset returns PC=0, state IDLE and count 0; the i_start from HALT restarts at PC=0 with the count preserved.
